ws2812_pattern_gen: RTL and testbench

- Parametrised pixel-colour source for the WS2812 serialiser; answers per-pixel colour requests for an arbitrary ROWS x COLS matrix.
- Colours come from a runtime-writable palette of N_COLORS entries.
- Pattern is selected by a mode input, and the palette rotates periodically in either direction.
- Sits between the WS2812 driver (leddata_addr/start/color) and control logic (keypad/debounce).

---
 rtl/ws2812_pattern_gen.sv | 147 ++++++++++++++
 tb/tb_ws2812_pattern_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_pattern_gen.sv
// Purpose: per-pixel colour source for a WS2812 matrix; pattern by mode over a rotating, writable palette.
// Latency: fixed 2 clk from the start rising edge to done; fully pipelined, one request per edge.
// Backpressure: none; every start edge is answered exactly once, and the consumer must take odata on done.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, iaddr          request strobe (rising edge) and pixel address {row, col}
//   mode, bright          pattern select and per-byte right shift, both captured on the edge
//   odata, done           registered pixel colour and its one-cycle valid pulse
//   dir, pause            palette rotation direction and hold
//   pal_we/waddr/wdata    synchronous palette write port
module ws2812_pattern_gen #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3,
  parameter int W_DATA   = 24,
  parameter int PAL_BITS = 3,
  parameter int PERIOD   = 30000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ROW_BITS+COL_BITS-1:0] iaddr,
  output logic [W_DATA-1:0]            odata,
  output logic                         done,
  input  logic [1:0]                   mode,
  input  logic                         dir,
  input  logic                         pause,
  input  logic [2:0]                   bright,
  input  logic                         pal_we,
  input  logic [PAL_BITS-1:0]          pal_waddr,
  input  logic [W_DATA-1:0]            pal_wdata
);

  localparam int N_COLORS = 1 << PAL_BITS;
  localparam int N_LANES  = W_DATA / 8;
  localparam int CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  // Power-on palette, GRB byte order, fitted to W_DATA.
  function automatic logic [W_DATA-1:0] default_color(input int i);
    logic [23:0] c;
    case (i % 8)
      0:       c = 24'h010F01;
      1:       c = 24'h0F1F01;
      2:       c = 24'h0F0F01;
      3:       c = 24'h0F0101;
      4:       c = 24'h01010F;
      5:       c = 24'h01012F;
      6:       c = 24'h01803F;
      default: c = 24'h0F0F0F;
    endcase
    return W_DATA'(c);
  endfunction

  logic                start_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PAL_BITS-1:0] rot_q, rot_d;
  logic                s1_vld_q, s1_vld_d;
  logic [PAL_BITS-1:0] idx_q, idx_d;
  logic [2:0]          bright_q, bright_d;
  logic [W_DATA-1:0]   odata_q, odata_d;
  logic                done_q, done_d;
  logic [W_DATA-1:0]   pal_q [N_COLORS];
  logic [W_DATA-1:0]   pal_d [N_COLORS];

  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [PAL_BITS-1:0] row_p, col_p, f_val;
  logic                edge_det;

  always_comb begin
    row      = iaddr[ROW_BITS+COL_BITS-1:COL_BITS];
    col      = iaddr[COL_BITS-1:0];
    row_p    = PAL_BITS'(row);
    col_p    = PAL_BITS'(col);
    case (mode)
      2'd0:    f_val = row_p ^ col_p;
      2'd1:    f_val = row_p + col_p;
      2'd2:    f_val = row_p;
      default: f_val = '0;
    endcase
    edge_det = start & ~start_q;

    // Rotation: step rot each time the period counter wraps.
    cnt_d = cnt_q;
    rot_d = rot_q;
    if (!pause) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        rot_d = dir ? rot_q - 1'b1 : rot_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Stage 1 uses the current rot_q, so a step landing on the edge cycle
    // does not affect this request.
    s1_vld_d = edge_det;
    idx_d    = edge_det ? f_val + rot_q : idx_q;
    bright_d = edge_det ? bright : bright_q;

    // Stage 2 reads pal_q before this cycle's write lands: old data on collision.
    done_d  = s1_vld_q;
    odata_d = odata_q;
    if (s1_vld_q) begin
      for (int l = 0; l < N_LANES; l++) begin
        odata_d[l*8 +: 8] = pal_q[idx_q][l*8 +: 8] >> bright_q;
      end
    end

    pal_d = pal_q;
    if (pal_we) begin
      pal_d[pal_waddr] = pal_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // start_q resets high so a start held through reset is not an edge.
      start_q  <= 1'b1;
      cnt_q    <= '0;
      rot_q    <= '0;
      s1_vld_q <= 1'b0;
      idx_q    <= '0;
      bright_q <= '0;
      odata_q  <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < N_COLORS; i++) begin
        pal_q[i] <= default_color(i);
      end
    end else begin
      start_q  <= start;
      cnt_q    <= cnt_d;
      rot_q    <= rot_d;
      s1_vld_q <= s1_vld_d;
      idx_q    <= idx_d;
      bright_q <= bright_d;
      odata_q  <= odata_d;
      done_q   <= done_d;
      pal_q    <= pal_d;
    end
  end

  assign odata = odata_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ws2812_pattern_gen.sv
`timescale 1ns/1ps
module tb_ws2812_pattern_gen;
  localparam int PERIOD = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, dir, pause, pal_we, done;
  logic [5:0]  iaddr;
  logic [1:0]  mode;
  logic [2:0]  bright, pal_waddr;
  logic [23:0] odata, pal_wdata;

  always #5 clk = ~clk;

  ws2812_pattern_gen #(
    .ROW_BITS(3), .COL_BITS(3), .W_DATA(24), .PAL_BITS(3), .PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iaddr(iaddr), .odata(odata), .done(done),
    .mode(mode), .dir(dir), .pause(pause), .bright(bright),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] dflt [8] = '{24'h010F01, 24'h0F1F01, 24'h0F0F01, 24'h0F0101,
                            24'h01010F, 24'h01012F, 24'h01803F, 24'h0F0F0F};

  // Reference: palette contents and rotation offset as seen by the next request.
  logic [23:0] pal_m [8];
  int          m_elapsed = 0;
  logic [2:0]  m_rot = 3'd0;
  logic [23:0] exp_hold = 24'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_elapsed <= 0;
      m_rot     <= 3'd0;
      for (int i = 0; i < 8; i++) pal_m[i] <= dflt[i];
    end else begin
      if (!pause) begin
        m_elapsed <= m_elapsed + 1;
        if ((m_elapsed + 1) % PERIOD == 0) m_rot <= dir ? m_rot - 3'd1 : m_rot + 3'd1;
      end
      if (pal_we) pal_m[pal_waddr] <= pal_wdata;
    end
  end

  function automatic logic [2:0] f_ref(input int row, input int col, input int md);
    case (md)
      0:       return 3'(row ^ col);
      1:       return 3'(row + col);
      2:       return 3'(row);
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [23:0] dim(input logic [23:0] c, input int sh);
    int g, r, b;
    g = int'(c) / 65536;
    r = (int'(c) / 256) % 256;
    b = int'(c) % 256;
    return 24'(((g >> sh) * 65536) + ((r >> sh) * 256) + (b >> sh));
  endfunction

  // Issue one request at a negedge (start low the cycle before) and return at
  // the negedge of the response cycle; optional palette write in the middle cycle.
  task automatic fire(input int row, input int col, input int md, input int br,
                      input logic wr, input int waddr, input logic [23:0] wdata,
                      output logic [23:0] exp, output logic done_e1);
    logic [2:0] idx;
    start  = 1'b1;
    iaddr  = 6'(row * 8 + col);
    mode   = 2'(md);
    bright = 3'(br);
    idx    = f_ref(row, col, md) + m_rot;
    @(posedge clk); @(negedge clk);
    done_e1 = done;
    exp     = dim(pal_m[idx], br);
    start   = 1'b0;
    if (wr) begin
      pal_we = 1'b1; pal_waddr = 3'(waddr); pal_wdata = wdata;
    end
    @(posedge clk); @(negedge clk);
    pal_we   = 1'b0;
    exp_hold = exp;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b1; pause = 1'b1; dir = 1'b0; mode = 2'd0; bright = 3'd0;
    iaddr = 6'd0; pal_we = 1'b0; pal_waddr = 3'd0; pal_wdata = 24'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (odata !== 24'h0) begin n_err++; $display("FAIL reset_odata: got %h expected 000000", odata); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL held_start_done: cycle %0d got %b expected 0", i, done); end
    end
    start = 1'b0;
    @(negedge clk);
    exp_hold = 24'h0;
  endtask

  task automatic test_basic();
    logic [23:0] exp;
    start = 1'b1; iaddr = 6'(3 * 8 + 5); mode = 2'd0; bright = 3'd0;
    exp = dim(pal_m[f_ref(3, 5, 0) + m_rot], 0);
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_early_done: got %b expected 0", done); end
    @(negedge clk);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b expected 1", done); end
    n_vec++; if (odata !== exp) begin n_err++; $display("FAIL basic_odata: got %h expected %h", odata, exp); end
    exp_hold = exp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_no_second_done: got %b expected 0", done); end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_modes();
    logic [23:0] exp;
    logic        d1;
    for (int md = 1; md < 4; md++) begin
      fire(2, 3, md, 0, 1'b0, 0, 24'h0, exp, d1);
      n_vec++; if (d1 !== 1'b0) begin n_err++; $display("FAIL mode%0d_early_done: got %b expected 0", md, d1); end
      n_vec++; if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL mode%0d: got done=%b %h expected done=1 %h", md, done, odata, exp); end
    end
    fire(0, 1, 0, 1, 1'b0, 0, 24'h0, exp, d1);
    n_vec++; if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL bright1: got done=%b %h expected done=1 %h", done, odata, exp); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || odata !== exp_hold) begin n_err++; $display("FAIL hold: got done=%b %h expected done=0 %h", done, odata, exp_hold); end
    end
  endtask

  task automatic test_rotation();
    logic [23:0] exp;
    logic        d1;
    dir = 1'b0; pause = 1'b0;
    repeat (3 * PERIOD) @(negedge clk);
    pause = 1'b1;
    fire(0, 0, 3, 0, 1'b0, 0, 24'h0, exp, d1);
    n_vec++; if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL rot_inc: got done=%b %h expected done=1 %h", done, odata, exp); end
    dir = 1'b1; pause = 1'b0;
    repeat (4 * PERIOD) @(negedge clk);
    pause = 1'b1;
    fire(0, 0, 3, 0, 1'b0, 0, 24'h0, exp, d1);
    n_vec++; if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL rot_dec_wrap: got done=%b %h expected done=1 %h", done, odata, exp); end
  endtask

  task automatic test_pause();
    logic [23:0] exp;
    logic        d1;
    bit          found;
    pause = 1'b1; dir = 1'b0;
    repeat (100) @(negedge clk);
    fire(0, 0, 3, 0, 1'b0, 0, 24'h0, exp, d1);
    n_vec++; if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL pause_hold: got done=%b %h expected done=1 %h", done, odata, exp); end
    pause = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      @(negedge clk);
      if (m_elapsed % PERIOD == PERIOD - 1) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++; $display("FAIL wrap_search: got no wrap cycle expected one within %0d cycles", 2 * PERIOD);
    end else begin
      fire(0, 0, 3, 0, 1'b0, 0, 24'h0, exp, d1);
      if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL wrap_edge: got done=%b %h expected done=1 %h", done, odata, exp); end
    end
    pause = 1'b1;
    fire(0, 0, 3, 0, 1'b0, 0, 24'h0, exp, d1);
    n_vec++; if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL after_wrap: got done=%b %h expected done=1 %h", done, odata, exp); end
  endtask

  task automatic test_collision();
    logic [23:0] exp;
    logic        d1;
    int          row;
    pause = 1'b1;
    row = (2 - int'(m_rot)) & 7;
    fire(row, 0, 2, 0, 1'b1, 2, 24'h123456, exp, d1);
    n_vec++; if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL collision_old: got done=%b %h expected done=1 %h", done, odata, exp); end
    fire(row, 0, 2, 0, 1'b0, 0, 24'h0, exp, d1);
    n_vec++; if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL collision_new: got done=%b %h expected done=1 %h", done, odata, exp); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] exp;
    logic        d1;
    start = 1'b1; iaddr = 6'd9; mode = 2'd1; bright = 3'd0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    exp_hold = 24'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || odata !== 24'h0) begin n_err++; $display("FAIL rst_mid: got done=%b %h expected done=0 000000", done, odata); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_release_done: got %b expected 0", done); end
    end
    fire(3, 5, 0, 0, 1'b0, 0, 24'h0, exp, d1);
    n_vec++; if (done !== 1'b1 || odata !== exp) begin n_err++; $display("FAIL rst_mid_first_req: got done=%b %h expected done=1 %h", done, odata, exp); end
  endtask

  // Random traffic including edges two cycles apart and palette writes that
  // may hit the entry being read; scoreboard keyed by response cycle.
  task automatic test_back_to_back();
    logic        sv [4];
    logic [2:0]  si [4];
    int          sb [4];
    logic [23:0] sc [4];
    logic        prev_start;
    int          k;
    for (int i = 0; i < 4; i++) begin sv[i] = 1'b0; si[i] = 3'd0; sb[i] = 0; sc[i] = 24'h0; end
    @(negedge clk);
    prev_start = start;
    for (int c = 0; c < 400; c++) begin
      k = c % 4;
      n_vec++; if (done !== sv[k]) begin n_err++; $display("FAIL rand_done: cycle %0d got %b expected %b", c, done, sv[k]); end
      if (sv[k]) exp_hold = sc[k];
      n_vec++; if (odata !== exp_hold) begin n_err++; $display("FAIL rand_odata: cycle %0d got %h expected %h", c, odata, exp_hold); end
      sv[k] = 1'b0;
      k = (c + 1) % 4;
      if (sv[k]) sc[k] = dim(pal_m[si[k]], sb[k]);
      start     = (c < 390) ? 1'($urandom_range(0, 1)) : 1'b0;
      iaddr     = 6'($urandom);
      mode      = 2'($urandom);
      bright    = 3'($urandom);
      dir       = 1'($urandom);
      pause     = ($urandom_range(0, 3) == 0);
      pal_we    = ($urandom_range(0, 5) == 0);
      pal_waddr = 3'($urandom);
      pal_wdata = 24'($urandom);
      if (start && !prev_start) begin
        k = (c + 2) % 4;
        sv[k] = 1'b1;
        si[k] = f_ref(int'(iaddr) / 8, int'(iaddr) % 8, int'(mode)) + m_rot;
        sb[k] = int'(bright);
      end
      prev_start = start;
      @(negedge clk);
    end
    pal_we = 1'b0;
    pause  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_rotation();
    test_pause();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
